// File: rtl/frac_div_pkg.sv
// Shared widths, iteration counts and FSM states for the fracturable 32/16 divider.
package frac_div_pkg;
    localparam int DVD_W      = 32;
    localparam int DIV_W      = 16;
    localparam int LANE_DVD_W = 16;
    localparam int LANE_DIV_W = 8;

    localparam int N_FULL  = 16;
    localparam int N_SPLIT = 8;
    localparam int CNT_W   = 5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;
endpackage

// File: rtl/frac_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial subtract, pick the quotient bit.
// With split=1 the W-bit datapath acts as two independent W/2 lanes; the borrow chain is cut at the midpoint.
module frac_div_step
    import frac_div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         split,
    input  logic [W-1:0] rem_in,
    input  logic [1:0]   bit_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out,
    output logic [1:0]   q_bit
);
    localparam int H = W / 2;

    logic [W:0]   sh_full;
    logic [H:0]   sh_hi;
    logic [H:0]   sh_lo;
    logic [H:0]   hi_op;
    logic [H:0]   lo_op;
    logic [H-1:0] hi_diff;
    logic [H-1:0] lo_diff;
    logic         lo_lt;
    logic         borrow_mid;

    always_comb begin
        sh_full = {rem_in, bit_in[1]};
        sh_hi   = {rem_in[W-1:H], bit_in[1]};
        sh_lo   = {rem_in[H-1:0], bit_in[0]};

        lo_op = split ? sh_lo : {1'b0, sh_full[H-1:0]};
        hi_op = split ? sh_hi : sh_full[W:H];

        // Lower-half borrow feeds the upper half only when the lanes are fused.
        lo_lt      = lo_op < {1'b0, divisor[H-1:0]};
        borrow_mid = ~split & lo_lt;

        lo_diff = lo_op[H-1:0] - divisor[H-1:0];
        hi_diff = hi_op[H-1:0] - divisor[W-1:H] - {{(H-1){1'b0}}, borrow_mid};

        q_bit[1] = (hi_op > {1'b0, divisor[W-1:H]}) |
                   ((hi_op == {1'b0, divisor[W-1:H]}) & ~borrow_mid);
        q_bit[0] = split ? ~lo_lt : q_bit[1];

        if (split) begin
            rem_out[W-1:H] = q_bit[1] ? hi_diff : sh_hi[H-1:0];
            rem_out[H-1:0] = q_bit[0] ? lo_diff : sh_lo[H-1:0];
        end else begin
            rem_out = q_bit[1] ? {hi_diff, lo_diff} : sh_full[W-1:0];
        end
    end
endmodule

// File: rtl/frac_div_32x16.sv
// Fracturable restoring divider: one 32/16 (17 cycles start-to-done) or two 16/8 (9 cycles).
// No backpressure: start is accepted only in IDLE, results are held until the next accepted start.
module frac_div_32x16
    import frac_div_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [0:0]  mode,
    input  logic [0:31] a,
    input  logic [0:15] b,
    output logic        busy,
    output logic        done,
    output logic [0:15] quotient,
    output logic [0:15] remainder,
    output logic [0:1]  div_by_zero,
    output logic [0:1]  overflow
);
    logic [DVD_W-1:0] a_v;
    logic [DIV_W-1:0] b_v;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic [15:0]      rem_q, rem_d;
    logic [15:0]      dvd_q, dvd_d;
    logic [15:0]      quo_q, quo_d;
    logic [15:0]      div_q, div_d;
    logic [15:0]      zrem_q, zrem_d;
    logic [1:0]       dbz_q, dbz_d;
    logic [1:0]       ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [15:0]      quotient_q, quotient_d;
    logic [15:0]      remainder_q, remainder_d;
    logic [1:0]       dbz_out_q, dbz_out_d;
    logic [1:0]       ovf_out_q, ovf_out_d;

    logic [15:0]      step_rem;
    logic [1:0]       step_q;

    // Internal vectors are little-endian; bit [1] of the flag pairs is lane 0.
    assign a_v = a;
    assign b_v = b;

    frac_div_step #(.W(DIV_W)) u_step (
        .split   (mode_q),
        .rem_in  (rem_q),
        .bit_in  ({dvd_q[15], dvd_q[7]}),
        .divisor (div_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        quo_d       = quo_q;
        div_d       = div_q;
        zrem_d      = zrem_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_out_d   = dbz_out_q;
        ovf_out_d   = ovf_out_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    mode_d  = mode[0];
                    div_d   = b_v;
                    quo_d   = '0;
                    if (!mode[0]) begin
                        cnt_d  = CNT_W'(N_FULL);
                        rem_d  = a_v[31:16];
                        dvd_d  = a_v[15:0];
                        zrem_d = a_v[15:0];
                        dbz_d  = {b_v == '0, 1'b0};
                        ovf_d  = {(b_v != '0) && (a_v[31:16] >= b_v), 1'b0};
                    end else begin
                        cnt_d  = CNT_W'(N_SPLIT);
                        rem_d  = {a_v[31:24], a_v[15:8]};
                        dvd_d  = {a_v[23:16], a_v[7:0]};
                        zrem_d = {a_v[23:16], a_v[7:0]};
                        dbz_d  = {b_v[15:8] == 8'd0, b_v[7:0] == 8'd0};
                        ovf_d  = {(b_v[15:8] != 8'd0) && (a_v[31:24] >= b_v[15:8]),
                                  (b_v[7:0] != 8'd0) && (a_v[15:8] >= b_v[7:0])};
                    end
                end
            end
            RUN: begin
                rem_d = step_rem;
                cnt_d = cnt_q - 1'b1;
                if (mode_q) begin
                    dvd_d = {dvd_q[14:8], 1'b0, dvd_q[6:0], 1'b0};
                    quo_d = {quo_q[14:8], step_q[1], quo_q[6:0], step_q[0]};
                end else begin
                    dvd_d = {dvd_q[14:0], 1'b0};
                    quo_d = {quo_q[14:0], step_q[1]};
                end
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    quotient_d  = quo_d;
                    remainder_d = rem_d;
                    dbz_out_d   = dbz_q;
                    ovf_out_d   = ovf_q;
                    // Flagged lanes ran the full count on garbage; substitute the defined results.
                    if (!mode_q) begin
                        if (dbz_q[1]) begin
                            quotient_d  = 16'hFFFF;
                            remainder_d = zrem_q;
                        end else if (ovf_q[1]) begin
                            quotient_d  = 16'hFFFF;
                            remainder_d = '0;
                        end
                    end else begin
                        if (dbz_q[1]) begin
                            quotient_d[15:8]  = 8'hFF;
                            remainder_d[15:8] = zrem_q[15:8];
                        end else if (ovf_q[1]) begin
                            quotient_d[15:8]  = 8'hFF;
                            remainder_d[15:8] = 8'h00;
                        end
                        if (dbz_q[0]) begin
                            quotient_d[7:0]  = 8'hFF;
                            remainder_d[7:0] = zrem_q[7:0];
                        end else if (ovf_q[0]) begin
                            quotient_d[7:0]  = 8'hFF;
                            remainder_d[7:0] = 8'h00;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            rem_q       <= '0;
            dvd_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            zrem_q      <= '0;
            dbz_q       <= '0;
            ovf_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_out_q   <= '0;
            ovf_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            quo_q       <= quo_d;
            div_q       <= div_d;
            zrem_q      <= zrem_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_out_q   <= dbz_out_d;
            ovf_out_q   <= ovf_out_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_out_q;
    assign overflow    = ovf_out_q;
endmodule
